// File: rtl/iopmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iopmp_pkg
// Description : Shared IOPMP types. Holds the access-type encoding seen by
//               the rule checker and the state encoding of the check arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package iopmp_pkg;

    // Access type presented to the rule checker.
    typedef enum logic [1:0] {
        ACCESS_NONE    = 2'd0,
        ACCESS_READ    = 2'd1,
        ACCESS_WRITE   = 2'd2,
        ACCESS_EXECUTE = 2'd3
    } iopmp_access_t;

    // Check arbiter sequencing: accept, check (one cycle), respond.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CHECK = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

endpackage : iopmp_pkg
`default_nettype wire

// File: rtl/iopmp_check_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : iopmp_check_arbiter_if
// Description : Bundle between the DMA requesters, the shared IOPMP checker
//               and the check arbiter.
//               slave  : arbiter side (requests/verdict in, grants/checker
//                        drive/verdicts/counters out)
//               master : environment side (requesters + checker)
//               Ports  : req_valid_i/req_ready_o/req_addr_i/req_access_i,
//                        rsp_valid_o/rsp_allow_o/rsp_ready_i,
//                        chk_valid_o/chk_addr_o/chk_sid_o/chk_access_o/
//                        chk_allow_i, cnt_clr_i, deny_cnt_o, busy_o
// Revision    : 1.0 - initial release
// ============================================================================
interface iopmp_check_arbiter_if #(
    parameter int NR_MASTERS = 2,
    parameter int PLEN       = 34,
    parameter int SID_W      = (NR_MASTERS == 1) ? 1 : $clog2(NR_MASTERS),
    parameter int CNT_W      = 16
);
    import iopmp_pkg::*;

    logic          [NR_MASTERS-1:0]            req_valid_i;
    logic          [NR_MASTERS-1:0]            req_ready_o;
    logic          [NR_MASTERS-1:0][PLEN-1:0]  req_addr_i;
    iopmp_access_t [NR_MASTERS-1:0]            req_access_i;

    logic          [NR_MASTERS-1:0]            rsp_valid_o;
    logic          [NR_MASTERS-1:0]            rsp_allow_o;
    logic          [NR_MASTERS-1:0]            rsp_ready_i;

    logic                                      chk_valid_o;
    logic          [PLEN-1:0]                  chk_addr_o;
    logic          [SID_W-1:0]                 chk_sid_o;
    iopmp_access_t                             chk_access_o;
    logic                                      chk_allow_i;

    logic                                      cnt_clr_i;
    logic          [NR_MASTERS-1:0][CNT_W-1:0] deny_cnt_o;
    logic                                      busy_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_access_i, rsp_ready_i,
               chk_allow_i, cnt_clr_i,
        output req_ready_o, rsp_valid_o, rsp_allow_o, chk_valid_o,
               chk_addr_o, chk_sid_o, chk_access_o, deny_cnt_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_access_i, rsp_ready_i,
               chk_allow_i, cnt_clr_i,
        input  req_ready_o, rsp_valid_o, rsp_allow_o, chk_valid_o,
               chk_addr_o, chk_sid_o, chk_access_o, deny_cnt_o, busy_o
    );

endinterface : iopmp_check_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Returns the first set request
//               bit searching upward from ptr, wrapping modulo NR_MASTERS.
//               req       : request vector
//               ptr       : highest-priority index
//               gnt_idx   : chosen index (0 when nothing requested)
//               gnt_valid : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NR_MASTERS = 2,
    parameter int SID_W      = (NR_MASTERS == 1) ? 1 : $clog2(NR_MASTERS)
) (
    input  logic [NR_MASTERS-1:0] req,
    input  logic [SID_W-1:0]      ptr,
    output logic [SID_W-1:0]      gnt_idx,
    output logic                  gnt_valid
);

    logic [SID_W-1:0] w_idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            // Candidate i positions after the pointer; the modulo keeps the
            // index inside the request vector for non power-of-two counts.
            w_idx = SID_W'((int'(ptr) + i) % NR_MASTERS);
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/iopmp_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iopmp_check_arbiter
// Description : Shares one combinational IOPMP rule checker between
//               NR_MASTERS DMA requesters. One request is in flight at a time:
//               IDLE accepts a round-robin grant, CHECK drives the checker for
//               exactly one cycle and registers its verdict, RESP returns the
//               verdict to the granted master. Keeps a saturating deny
//               counter per master.
//               clk_i  : clock
//               rst_ni : asynchronous active-low reset
//               bus    : iopmp_check_arbiter_if.slave (requests, responses,
//                        checker drive/verdict, counters, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module iopmp_check_arbiter
    import iopmp_pkg::*;
#(
    parameter int NR_MASTERS = 2,
    parameter int PLEN       = 34,
    parameter int SID_W      = (NR_MASTERS == 1) ? 1 : $clog2(NR_MASTERS),
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    iopmp_check_arbiter_if.slave  bus
);

    localparam logic [SID_W-1:0] c_last_idx = SID_W'(NR_MASTERS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    arb_state_e                           r_state;
    arb_state_e                           w_state_nxt;
    logic          [SID_W-1:0]            r_rr;
    logic          [SID_W-1:0]            r_gnt;
    logic          [PLEN-1:0]             r_addr;
    iopmp_access_t                        r_access;
    logic                                 r_allow;
    logic          [NR_MASTERS-1:0][CNT_W-1:0] r_deny_cnt;

    logic          [SID_W-1:0]            w_arb_idx;
    logic                                 w_arb_valid;
    logic                                 w_grant;
    logic                                 w_check;
    logic                                 w_rsp_done;

    rr_arbiter #(
        .NR_MASTERS (NR_MASTERS),
        .SID_W      (SID_W)
    ) u_rr_arbiter (
        .req        (bus.req_valid_i),
        .ptr        (r_rr),
        .gnt_idx    (w_arb_idx),
        .gnt_valid  (w_arb_valid)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_grant         = 1'b0;
        w_check         = 1'b0;
        w_rsp_done      = 1'b0;
        bus.req_ready_o = '0;
        bus.rsp_valid_o = '0;
        bus.rsp_allow_o = '0;
        bus.chk_valid_o = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_arb_valid) begin
                    w_grant                    = 1'b1;
                    bus.req_ready_o[w_arb_idx] = 1'b1;
                    w_state_nxt                = ARB_CHECK;
                end
            end
            ARB_CHECK: begin
                bus.chk_valid_o = 1'b1;
                w_check         = 1'b1;
                w_state_nxt     = ARB_RESP;
            end
            ARB_RESP: begin
                bus.rsp_valid_o[r_gnt] = 1'b1;
                bus.rsp_allow_o[r_gnt] = r_allow;
                if (bus.rsp_ready_i[r_gnt]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latched request, verdict and round-robin pointer. The checker inputs
    // come straight from these registers so they never glitch and simply
    // hold outside CHECK.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gnt    <= '0;
            r_addr   <= '0;
            r_access <= ACCESS_NONE;
            r_allow  <= 1'b0;
            r_rr     <= '0;
        end else begin
            if (w_grant) begin
                r_gnt    <= w_arb_idx;
                r_addr   <= bus.req_addr_i[w_arb_idx];
                r_access <= bus.req_access_i[w_arb_idx];
            end
            if (w_check) begin
                r_allow <= bus.chk_allow_i;
            end
            // Pointer moves only on response completion, just past the
            // master that was served.
            if (w_rsp_done) begin
                r_rr <= (r_gnt == c_last_idx) ? '0 : r_gnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating per-master deny counters; clear beats a same-cycle deny.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_deny_cnt <= '0;
        end else if (bus.cnt_clr_i) begin
            r_deny_cnt <= '0;
        end else if (w_check && !bus.chk_allow_i) begin
            for (int m = 0; m < NR_MASTERS; m++) begin
                if ((r_gnt == SID_W'(m)) && (r_deny_cnt[m] != c_cnt_max)) begin
                    r_deny_cnt[m] <= r_deny_cnt[m] + 1'b1;
                end
            end
        end
    end

    assign bus.chk_addr_o   = r_addr;
    assign bus.chk_sid_o    = r_gnt;
    assign bus.chk_access_o = r_access;
    assign bus.deny_cnt_o   = r_deny_cnt;
    assign bus.busy_o       = (r_state != ARB_IDLE);

endmodule : iopmp_check_arbiter
`default_nettype wire

// File: tb/tb_iopmp_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iopmp_check_arbiter
// Description : Self-checking bench for iopmp_check_arbiter (2 masters,
//               4-bit deny counters). A transaction-level model keeps the
//               round-robin pointer, pending requests and deny counts; a
//               behavioural checker model supplies the verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iopmp_check_arbiter;
    import iopmp_pkg::*;

    localparam int N       = 2;
    localparam int PLEN    = 34;
    localparam int SID_W   = 1;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk;
    logic rst_n;

    iopmp_check_arbiter_if #(
        .NR_MASTERS (N), .PLEN (PLEN), .SID_W (SID_W), .CNT_W (CNT_W)
    ) bus ();

    iopmp_check_arbiter #(
        .NR_MASTERS (N), .PLEN (PLEN), .SID_W (SID_W), .CNT_W (CNT_W)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model state ----------------
    int            n_chk;
    int            n_pass;
    int            rr_m;
    int            cnt_m [N];
    bit            pend  [N];
    logic [PLEN-1:0] p_addr [N];
    iopmp_access_t p_acc [N];
    bit            force_deny;
    time           rsp_t;

    // Rule checker model: low 2 GiB only, some access required, and SID 1
    // may not execute.
    function automatic bit ref_allow(input logic [PLEN-1:0] a,
                                     input iopmp_access_t acc, input int sid);
        return (acc != ACCESS_NONE) && (a < 34'h0_8000_0000) &&
               !(sid == 1 && acc == ACCESS_EXECUTE);
    endfunction

    always_comb begin
        bus.chk_allow_i = !force_deny &&
            ref_allow(bus.chk_addr_o, bus.chk_access_o, int'(bus.chk_sid_o));
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] exp_cnt_vec();
        logic [63:0] v;
        v = '0;
        for (int m = 0; m < N; m++) v |= 64'(cnt_m[m]) << (m * CNT_W);
        return v;
    endfunction

    task automatic model_reset();
        rr_m = 0;
        for (int m = 0; m < N; m++) begin
            cnt_m[m] = 0;
            pend[m]  = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, 64'(bus.req_ready_o), 0);
        check_eq({tag, "_rsp"}, 64'({bus.rsp_valid_o, bus.rsp_allow_o}), 0);
        check_eq({tag, "_chk_valid"}, 64'(bus.chk_valid_o), 0);
        check_eq({tag, "_chk_bus"},
                 64'({bus.chk_addr_o, bus.chk_sid_o, bus.chk_access_o}), 0);
        check_eq({tag, "_deny_cnt"}, 64'(bus.deny_cnt_o), 0);
        check_eq({tag, "_busy"}, 64'(bus.busy_o), 0);
    endtask

    task automatic drive_reqs();
        for (int m = 0; m < N; m++) begin
            bus.req_valid_i[m]  = pend[m];
            bus.req_addr_i[m]   = p_addr[m];
            bus.req_access_i[m] = p_acc[m];
        end
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        bus.req_valid_i = '0;
        bus.rsp_ready_i = '0;
        bus.cnt_clr_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One full transaction starting with the DUT in IDLE, just after a
    // rising edge. bp = cycles of response back-pressure, clr = clear the
    // counters during CHECK, wd = other idle masters pulse a request that
    // is withdrawn before the arbiter is free again.
    task automatic do_round(input int bp, input bit clr, input bit wd,
                            output int g);
        bit             exp;
        int             cand;
        logic [N-1:0]   onehot;
        bit             any;
        drive_reqs();
        any = 1'b0;
        for (int m = 0; m < N; m++) any |= pend[m];
        if (!any) begin
            g = -1;
            @(negedge clk);
            check_eq("idle_req_ready", 64'(bus.req_ready_o), 0);
            check_eq("idle_busy", 64'(bus.busy_o), 0);
            check_eq("idle_rsp_valid", 64'(bus.rsp_valid_o), 0);
            @(posedge clk);
            #1;
            return;
        end
        g = -1;
        for (int i = 0; i < N; i++) begin
            cand = (rr_m + i) % N;
            if (g < 0 && pend[cand]) g = cand;
        end
        exp       = ref_allow(p_addr[g], p_acc[g], g) && !force_deny;
        onehot    = '0;
        onehot[g] = 1'b1;

        @(negedge clk);
        check_eq("req_ready", 64'(bus.req_ready_o), 64'(onehot));
        check_eq("busy_idle", 64'(bus.busy_o), 0);
        check_eq("chk_valid_idle", 64'(bus.chk_valid_o), 0);
        @(posedge clk);
        #1;
        bus.req_valid_i[g] = 1'b0;
        pend[g]            = 1'b0;
        bus.cnt_clr_i      = clr;
        if (wd) for (int m = 0; m < N; m++) if (!pend[m]) bus.req_valid_i[m] = 1'b1;

        @(negedge clk);
        check_eq("chk_valid", 64'(bus.chk_valid_o), 1);
        check_eq("chk_sid", 64'(bus.chk_sid_o), 64'(g));
        check_eq("chk_addr", 64'(bus.chk_addr_o), 64'(p_addr[g]));
        check_eq("chk_access", 64'(bus.chk_access_o), 64'(p_acc[g]));
        check_eq("req_ready_check", 64'(bus.req_ready_o), 0);
        check_eq("busy_check", 64'(bus.busy_o), 1);
        if (clr) begin
            for (int m = 0; m < N; m++) cnt_m[m] = 0;
        end else if (!exp && cnt_m[g] < CNT_MAX) begin
            cnt_m[g]++;
        end
        @(posedge clk);
        #1;
        bus.cnt_clr_i = 1'b0;
        if (wd) for (int m = 0; m < N; m++) if (!pend[m]) bus.req_valid_i[m] = 1'b0;

        for (int k = 0; k <= bp; k++) begin
            bus.rsp_ready_i = (k == bp) ? onehot : (N'($urandom) & ~onehot);
            @(negedge clk);
            if (k == 0) rsp_t = $time;
            check_eq("rsp_valid", 64'(bus.rsp_valid_o), 64'(onehot));
            check_eq("rsp_allow", 64'(bus.rsp_allow_o), exp ? 64'(onehot) : 0);
            check_eq("busy_resp", 64'(bus.busy_o), 1);
            check_eq("chk_valid_resp", 64'(bus.chk_valid_o), 0);
            check_eq("deny_cnt", 64'(bus.deny_cnt_o), exp_cnt_vec());
            @(posedge clk);
            #1;
        end
        bus.rsp_ready_i = '0;
        rr_m            = (g + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g;
        time prev_t;
        n_chk            = 0;
        n_pass           = 0;
        force_deny       = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_access_i = '{default: ACCESS_NONE};
        for (int m = 0; m < N; m++) begin
            p_addr[m] = '0;
            p_acc[m]  = ACCESS_NONE;
        end
        apply_reset();

        // Single request: master 0, 0x1000 read, allowed.
        pend[0] = 1'b1; p_addr[0] = 34'h1000; p_acc[0] = ACCESS_READ;
        do_round(0, 1'b0, 1'b0, g);
        check_eq("single_grant", 64'(g), 0);
        check_eq("single_deny_cnt0", 64'(bus.deny_cnt_o[0]), 0);

        // Fairness: both masters request continuously from reset.
        apply_reset();
        p_addr[0] = 34'h2000; p_acc[0] = ACCESS_WRITE;
        p_addr[1] = 34'h3000; p_acc[1] = ACCESS_READ;
        pend[0] = 1'b1; pend[1] = 1'b1;
        prev_t = 0;
        for (int r = 0; r < 4; r++) begin
            do_round(0, 1'b0, 1'b0, g);
            check_eq("fair_order", 64'(g), 64'(r % 2));
            if (r > 0) check_eq("fair_spacing_ns", 64'(rsp_t - prev_t), 30);
            prev_t  = rsp_t;
            pend[g] = 1'b1;
        end
        pend[0] = 1'b0; pend[1] = 1'b0;

        // Deny with 5 cycles of back-pressure on master 1.
        force_deny = 1'b1;
        pend[1] = 1'b1; p_addr[1] = 34'h4000; p_acc[1] = ACCESS_READ;
        do_round(5, 1'b0, 1'b0, g);
        check_eq("deny_grant", 64'(g), 1);
        check_eq("deny_cnt1", 64'(bus.deny_cnt_o[1]), 1);
        force_deny = 1'b0;

        // Withdrawn request from master 1 while master 0 is served.
        pend[0] = 1'b1; p_addr[0] = 34'h5000; p_acc[0] = ACCESS_READ;
        do_round(1, 1'b0, 1'b1, g);
        check_eq("withdraw_grant", 64'(g), 0);
        do_round(0, 1'b0, 1'b0, g);

        // Saturation: 17 denies from master 0, then clear against a deny.
        force_deny = 1'b1;
        for (int r = 0; r < 17; r++) begin
            pend[0] = 1'b1;
            do_round(0, 1'b0, 1'b0, g);
        end
        check_eq("sat_cnt0", 64'(bus.deny_cnt_o[0]), 15);
        pend[0] = 1'b1;
        do_round(0, 1'b1, 1'b0, g);
        check_eq("clr_wins_cnt0", 64'(bus.deny_cnt_o[0]), 0);
        force_deny = 1'b0;

        // Reset during RESP of master 1 (pointer was at 1).
        pend[0] = 1'b1;
        do_round(0, 1'b0, 1'b0, g);
        pend[1] = 1'b1; p_addr[1] = 34'h6000; p_acc[1] = ACCESS_WRITE;
        drive_reqs();
        @(negedge clk);
        check_eq("rst_req_ready", 64'(bus.req_ready_o), 2);
        @(posedge clk);
        #1 bus.req_valid_i[1] = 1'b0;
        pend[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_pre_rsp_valid", 64'(bus.rsp_valid_o), 2);
        #1 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_rsp", 64'(bus.rsp_valid_o), 0);
            check_eq("rst_idle_busy", 64'(bus.busy_o), 0);
        end
        @(posedge clk);
        #1;
        pend[0] = 1'b1; pend[1] = 1'b1;
        do_round(0, 1'b0, 1'b0, g);
        check_eq("rr_after_reset", 64'(g), 0);

        // Randomized traffic against the model.
        for (int r = 0; r < 60; r++) begin
            for (int m = 0; m < N; m++) begin
                if (!pend[m] && $urandom_range(0, 9) < 6) begin
                    pend[m]   = 1'b1;
                    p_addr[m] = ($urandom_range(0, 1) == 1) ?
                                {3'b000, 31'($urandom)} :
                                {2'($urandom), 32'($urandom)};
                    p_acc[m]  = iopmp_access_t'($urandom_range(0, 3));
                end
            end
            force_deny = ($urandom_range(0, 3) == 0);
            do_round($urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 3) == 0), g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_iopmp_check_arbiter
`default_nettype wire
